// File: rtl/ibus_mem_responder.sv
// ibus_mem_responder
//   Responder end of the instruction bus. A fetch request is accepted from
//   IDLE, answered with one data_ok cycle after LATENCY cycles, and served
//   from an internal word-addressed store that is filled through a load port.
//
// Ports
//   i_clk            clock; all state changes on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_ireq_valid     fetch request valid (held by the initiator until data_ok)
//   i_ireq_addr      fetch byte address (64 bit)
//   o_iresp_addr_ok  high for the one cycle after a request is accepted
//   o_iresp_data_ok  high for exactly one cycle when the response is ready
//   o_iresp_data     instruction word, zero outside data_ok cycles
//   o_fault          high with data_ok for misaligned / out-of-range requests
//   i_ld_en          preload write strobe
//   i_ld_idx         preload word index
//   i_ld_data        preload word
module ibus_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_ireq_valid,
    input  logic [63:0]                    i_ireq_addr,
    output logic                           o_iresp_addr_ok,
    output logic                           o_iresp_data_ok,
    output logic [31:0]                    o_iresp_data,
    output logic                           o_fault,
    input  logic                           i_ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_ld_idx,
    input  logic [31:0]                    i_ld_data
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam logic [1:0]  BASE_LO = BASE_ADDR[1:0];
    localparam logic [31:0] NOP     = 32'h0000_0013;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_addr;
    logic        r_addr_ok;
    logic [31:0] r_data;
    logic        r_fault;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [1:0]    w_next;
    logic [3:0]    w_cnt_next;
    logic          w_accept;
    logic [64:0]   w_offset;
    logic          w_below;
    logic          w_above;
    logic          w_misalign;
    logic          w_fault;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_resp_data;

    // 65-bit subtraction: bit 64 is the borrow (addr below BASE), and any
    // set bit above the word index means addr >= BASE + 4*DEPTH, so the
    // range check never wraps at the top of the address space.
    assign w_offset   = {1'b0, i_ireq_addr} - {1'b0, BASE_ADDR};
    assign w_below    = w_offset[64];
    assign w_above    = |w_offset[63:AW+2];
    assign w_idx      = w_offset[AW+1:2];
    // Adding BASE back on the low two bits recovers addr[1:0].
    assign w_misalign = (w_offset[1:0] + BASE_LO) != 2'b00;
    assign w_fault    = w_below | w_above | w_misalign;

    // Write-first: a preload to the index being read on the same edge wins.
    assign w_rd_word   = (i_ld_en && (i_ld_idx == w_idx)) ? i_ld_data : r_mem[w_idx];
    assign w_resp_data = w_fault ? NOP : w_rd_word;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_ireq_valid) begin
                    w_accept   = 1'b1;
                    w_cnt_next = LAT_M1;
                    w_next     = (LATENCY > 1) ? S_BUSY : S_RESP;
                end
            end
            S_BUSY: begin
                if (!i_ireq_valid || (i_ireq_addr != r_addr)) begin
                    w_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_next = S_RESP;
                    end
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Entry into RESP only happens while i_ireq_addr equals the accepted
    // address, so the read index can always be taken from the live request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_addr_ok <= 1'b0;
            r_data    <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_addr_ok <= w_accept;
            if (w_accept) begin
                r_addr <= i_ireq_addr;
            end
            if (w_next == S_RESP) begin
                r_data  <= w_resp_data;
                r_fault <= w_fault;
            end else begin
                r_data  <= '0;
                r_fault <= 1'b0;
            end
        end
    end

    // Instruction store: not cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_ld_en) begin
            r_mem[i_ld_idx] <= i_ld_data;
        end
    end

    assign o_iresp_addr_ok = r_addr_ok;
    assign o_iresp_data_ok = (r_state == S_RESP);
    assign o_iresp_data    = r_data;
    assign o_fault         = r_fault;

endmodule

// File: tb/tb_ibus_mem_responder.sv
`timescale 1ns/1ps
module tb_ibus_mem_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    // Index 0: LATENCY=1 instance, index 1: LATENCY=2 instance.
    logic        valid   [2];
    logic [63:0] addr    [2];
    logic        ld_en   [2];
    logic [3:0]  ld_idx  [2];
    logic [31:0] ld_data [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] data    [2];
    logic        fault   [2];

    ibus_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ireq_valid(valid[0]), .i_ireq_addr(addr[0]),
        .o_iresp_addr_ok(addr_ok[0]), .o_iresp_data_ok(data_ok[0]),
        .o_iresp_data(data[0]), .o_fault(fault[0]),
        .i_ld_en(ld_en[0]), .i_ld_idx(ld_idx[0]), .i_ld_data(ld_data[0])
    );

    ibus_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut_l2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ireq_valid(valid[1]), .i_ireq_addr(addr[1]),
        .o_iresp_addr_ok(addr_ok[1]), .o_iresp_data_ok(data_ok[1]),
        .o_iresp_data(data[1]), .o_fault(fault[1]),
        .i_ld_en(ld_en[1]), .i_ld_idx(ld_idx[1]), .i_ld_data(ld_data[1])
    );

    // Preload image: addi x1..x16, hand-written.
    logic [31:0] PRE [16] = '{
        32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213,
        32'h0050_0293, 32'h0060_0313, 32'h0070_0393, 32'h0080_0413,
        32'h0090_0493, 32'h00a0_0513, 32'h00b0_0593, 32'h00c0_0613,
        32'h00d0_0693, 32'h00e0_0713, 32'h00f0_0793, 32'h0100_0813
    };

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
        logic [31:0] cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cyc     = '0;
    bit          started = 1'b0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic int lat(input int k);
        return k + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d, input logic f, input logic [31:0] c);
        exp_t e;
        e.data  = d;
        e.fault = f;
        e.cyc   = c;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called at a negedge with the DUT in IDLE. The request is accepted on the
    // next edge (or 'delay' edges later); returns at the negedge after RESP.
    task automatic fetch(input int k, input logic [63:0] a, input logic [31:0] d,
                         input logic f, input int delay);
        valid[k] = 1'b1;
        addr[k]  = a;
        push(k, d, f, cyc + 32'(delay + lat(k)));
        @(negedge clk);
        if (delay == 0) chk($sformatf("addr_ok_dut%0d", k), 64'(addr_ok[k]), 64'd1);
        repeat (delay + lat(k) - 1) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic preload_both(input int i, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            ld_en[k]   = 1'b1;
            ld_idx[k]  = 4'(i);
            ld_data[k] = d;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) ld_en[k] = 1'b0;
    endtask

    task automatic mon(input int k);
        exp_t e;
        bit   empty;
        if (data_ok[k]) begin
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            n_tests++;
            if (empty) begin
                n_fail++;
                $display("FAIL spurious_data_ok_dut%0d: got data_ok=1 data=%h, required no response", k, data[k]);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("resp_data_dut%0d", k),  64'(data[k]),  64'(e.data));
                chk($sformatf("resp_fault_dut%0d", k), 64'(fault[k]), 64'(e.fault));
                chk($sformatf("resp_cycle_dut%0d", k), 64'(cyc),      64'(e.cyc));
            end
        end else begin
            chk($sformatf("idle_outputs_dut%0d", k), 64'({data[k], fault[k]}), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            valid[k]   = 1'b0;
            addr[k]    = '0;
            ld_en[k]   = 1'b0;
            ld_idx[k]  = '0;
            ld_data[k] = '0;
        end

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_addr_ok", 64'(addr_ok[k]), 64'd0);
            chk("rst_data_ok", 64'(data_ok[k]), 64'd0);
            chk("rst_data",    64'(data[k]),    64'd0);
            chk("rst_fault",   64'(fault[k]),   64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        started = 1'b1;

        for (int i = 0; i < 16; i++) preload_both(i, PRE[i]);

        // LATENCY=2 basic reads, including the last in-range word
        fetch(1, BASE,                PRE[0],  1'b0, 0);
        fetch(1, BASE + 64'd4,        PRE[1],  1'b0, 0);
        fetch(1, BASE + 64'd60,       PRE[15], 1'b0, 0);
        valid[1] = 1'b0;

        // LATENCY=1 continuous sequential fetch
        for (int i = 0; i < 8; i++) fetch(0, BASE + 64'(4 * i), PRE[i], 1'b0, 0);
        fetch(0, BASE + 64'd1, NOP, 1'b1, 0);
        valid[0] = 1'b0;
        @(negedge clk);

        // Abort by address change: old request dropped, new one re-accepted
        valid[1] = 1'b1;
        addr[1]  = BASE;
        @(negedge clk);
        chk("abort_addr_ok", 64'(addr_ok[1]), 64'd1);
        fetch(1, BASE + 64'd8, PRE[2], 1'b0, 1);
        valid[1] = 1'b0;

        // Abort by valid drop: no response at all
        @(negedge clk);
        valid[1] = 1'b1;
        addr[1]  = BASE + 64'd4;
        @(negedge clk);
        valid[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Faults (misaligned, below base, one past end, top of space, zero)
        fetch(1, BASE + 64'd2,               NOP,     1'b1, 0);
        fetch(1, 64'h0000_0000_7FFF_FFFC,    NOP,     1'b1, 0);
        fetch(1, BASE + 64'(4 * DEPTH),      NOP,     1'b1, 0);
        fetch(1, 64'hFFFF_FFFF_FFFF_FFFC,    NOP,     1'b1, 0);
        fetch(1, BASE + 64'(4 * DEPTH - 4),  PRE[15], 1'b0, 0);
        fetch(1, 64'h0,                      NOP,     1'b1, 0);
        valid[1] = 1'b0;
        @(negedge clk);

        // Reset asserted mid-BUSY
        valid[1] = 1'b1;
        addr[1]  = BASE + 64'd20;
        @(negedge clk);
        chk("busy_addr_ok", 64'(addr_ok[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_addr_ok", 64'(addr_ok[1]), 64'd0);
        chk("async_rst_data_ok", 64'(data_ok[1]), 64'd0);
        chk("async_rst_data",    64'(data[1]),    64'd0);
        chk("async_rst_fault",   64'(fault[1]),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(1, BASE + 64'd20, PRE[5], 1'b0, 0);
        valid[1] = 1'b0;
        @(negedge clk);

        // Write-first on RESP entry, LATENCY=2 (entry one edge after acceptance)
        valid[1] = 1'b1;
        addr[1]  = BASE + 64'd12;
        push(1, 32'hCAFE_0F13, 1'b0, cyc + 32'd2);
        @(negedge clk);
        ld_en[1]   = 1'b1;
        ld_idx[1]  = 4'd3;
        ld_data[1] = 32'hCAFE_0F13;
        @(negedge clk);
        ld_en[1] = 1'b0;
        @(negedge clk);
        fetch(1, BASE + 64'd12, 32'hCAFE_0F13, 1'b0, 0);
        valid[1] = 1'b0;

        // Write-first on RESP entry, LATENCY=1 (entry is the acceptance edge)
        valid[0]   = 1'b1;
        addr[0]    = BASE + 64'd28;
        ld_en[0]   = 1'b1;
        ld_idx[0]  = 4'd7;
        ld_data[0] = 32'h1234_5013;
        push(0, 32'h1234_5013, 1'b0, cyc + 32'd1);
        @(negedge clk);
        ld_en[0] = 1'b0;
        valid[0] = 1'b0;
        @(negedge clk);

        repeat (4) @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
